// File: rtl/duck_shot_judge_if.sv
// ---------------------------------------------------------------------------
// duck_shot_judge_if
//   Signal bundle between the gameplay front end (trigger, crosshair, duck
//   position) and the shot judge, plus the judge's results towards the
//   dog/duck animation controller and the score display.
//
//   master : the side that drives round/trigger/position inputs and consumes
//            kill pulse, shell count, round flags and score.
//   slave  : the shot judge itself.
//
//   Signals
//     round_start       level, new duck launched
//     duck_live         duck currently shootable
//     Trigger           raw trigger level, synchronous to ANIM_Clk
//     Cross_X/Cross_Y   crosshair position (10 bit)
//     Duck_X/Duck_Y     duck top-left position (10 bit)
//     Duck_color        0 black, 1 red, 2 pink, 3 black
//     duck_kill_signal  one-frame hit pulse
//     shells_left       remaining shots for this duck (3 bit)
//     round_hit         duck killed this round (sticky)
//     fly_away          shells exhausted without a hit (sticky)
//     Score_BCD         4-digit BCD score
//     flash             screen flash, only when SHOT_FLASH_EN is defined
// ---------------------------------------------------------------------------
interface duck_shot_judge_if;
  logic        round_start;
  logic        duck_live;
  logic        Trigger;
  logic [9:0]  Cross_X;
  logic [9:0]  Cross_Y;
  logic [9:0]  Duck_X;
  logic [9:0]  Duck_Y;
  logic [1:0]  Duck_color;
  logic        duck_kill_signal;
  logic [2:0]  shells_left;
  logic        round_hit;
  logic        fly_away;
  logic [15:0] Score_BCD;
`ifdef SHOT_FLASH_EN
  logic        flash;
`endif

  modport master (
    output round_start, duck_live, Trigger,
    output Cross_X, Cross_Y, Duck_X, Duck_Y, Duck_color,
    input  duck_kill_signal, shells_left, round_hit, fly_away, Score_BCD
`ifdef SHOT_FLASH_EN
    , input flash
`endif
  );

  modport slave (
    input  round_start, duck_live, Trigger,
    input  Cross_X, Cross_Y, Duck_X, Duck_Y, Duck_color,
    output duck_kill_signal, shells_left, round_hit, fly_away, Score_BCD
`ifdef SHOT_FLASH_EN
    , output flash
`endif
  );
endinterface

// File: rtl/duck_shot_judge.sv
// ---------------------------------------------------------------------------
// duck_shot_judge
//   Sits upstream of the dog/duck animation controller. Edge-detects the
//   player trigger, hit-tests the crosshair against the duck's box, tracks
//   the shell budget per duck, keeps a saturating BCD score and produces the
//   one-frame duck_kill_signal pulse plus round outcome flags.
//
//   Ports
//     ANIM_Clk  frame-rate clock, rising edge
//     Reset     asynchronous, active-high
//     bus       duck_shot_judge_if.slave (inputs and results, see interface)
//
//   Optional feature: define SHOT_FLASH_EN to add bus.flash, high during the
//   evaluation frame and the frame after it.
// ---------------------------------------------------------------------------
module duck_shot_judge #(
  parameter int DUCK_W      = 32,
  parameter int DUCK_H      = 32,
  parameter int SHELLS      = 3,
  parameter int COOL_FRAMES = 4
) (
  input  logic             ANIM_Clk,
  input  logic             Reset,
  duck_shot_judge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    EVAL  = 3'd2,
    COOL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0]  SHELLS_INIT = 3'(SHELLS);
  localparam logic [3:0]  COOL_LAST   = 4'(COOL_FRAMES - 1);
  localparam logic [10:0] W_SPAN      = 11'(DUCK_W - 1);
  localparam logic [10:0] H_SPAN      = 11'(DUCK_H - 1);

  state_t      state_reg, state_next;
  logic        trig_q_reg;
  logic [2:0]  shells_reg;
  logic [3:0]  cool_cnt_reg;
  logic [9:0]  cross_x_reg, cross_y_reg, duck_x_reg, duck_y_reg;
  logic [1:0]  color_reg;
  logic        live_reg;
  logic        kill_reg;
  logic        round_hit_reg;
  logic        fly_away_reg;
  logic [15:0] score_reg;

  logic        trig_edge;
  logic        shot_fire;
  logic        hit;
  logic [10:0] x_hi, y_hi;
  logic [15:0] addend;
  logic [15:0] bcd_sum;
  logic [15:0] score_add;

  assign trig_edge = bus.Trigger & ~trig_q_reg;
  // round_start wins over a coincident trigger edge, which is simply dropped.
  assign shot_fire = (state_reg == ARMED) & trig_edge & (shells_reg != 3'd0)
                     & ~bus.round_start;

  // 11-bit box bounds so a duck near x/y = 1023 does not wrap to 0.
  assign x_hi = {1'b0, duck_x_reg} + W_SPAN;
  assign y_hi = {1'b0, duck_y_reg} + H_SPAN;

  // A shot fired while the duck was not live stays a miss even if the duck
  // becomes live during the evaluation frame.
  assign hit = live_reg & bus.duck_live
             & ({1'b0, cross_x_reg} >= {1'b0, duck_x_reg})
             & ({1'b0, cross_x_reg} <= x_hi)
             & ({1'b0, cross_y_reg} >= {1'b0, duck_y_reg})
             & ({1'b0, cross_y_reg} <= y_hi);

  always_comb begin
    addend = 16'h0005;
    case (color_reg)
      2'd1:    addend = 16'h0015;
      2'd2:    addend = 16'h0010;
      default: addend = 16'h0005;
    endcase
  end

  // Ripple BCD adder, one digit per stage; a carry out of the top digit
  // means the result exceeded 9999 and the score clamps.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic       c_in;
    logic       c_out;
    logic [4:0] raw;
    logic [4:0] adj;

    if (gi == 0) begin : g_c0
      assign c_in = 1'b0;
    end else begin : g_cn
      assign c_in = g_digit[gi-1].c_out;
    end

    assign raw   = {1'b0, score_reg[4*gi +: 4]} + {1'b0, addend[4*gi +: 4]}
                 + {4'b0000, c_in};
    assign c_out = (raw > 5'd9);
    assign adj   = raw - 5'd10;
    assign bcd_sum[4*gi +: 4] = c_out ? adj[3:0] : raw[3:0];
  end

  assign score_add = g_digit[3].c_out ? 16'h9999 : bcd_sum;

  // State register
  always_ff @(posedge ANIM_Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (bus.round_start) begin
      state_next = ARMED;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        ARMED:   if (shot_fire) state_next = EVAL;
        EVAL: begin
          if (hit || shells_reg == 3'd0) state_next = DONE;
          else                           state_next = COOL;
        end
        COOL:    if (cool_cnt_reg == COOL_LAST) state_next = ARMED;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge ANIM_Clk or posedge Reset) begin
    if (Reset) begin
      trig_q_reg    <= 1'b0;
      shells_reg    <= SHELLS_INIT;
      cool_cnt_reg  <= 4'd0;
      cross_x_reg   <= 10'd0;
      cross_y_reg   <= 10'd0;
      duck_x_reg    <= 10'd0;
      duck_y_reg    <= 10'd0;
      color_reg     <= 2'd0;
      live_reg      <= 1'b0;
      kill_reg      <= 1'b0;
      round_hit_reg <= 1'b0;
      fly_away_reg  <= 1'b0;
      score_reg     <= 16'h0000;
    end else begin
      trig_q_reg <= bus.Trigger;
      kill_reg   <= 1'b0;
      if (bus.round_start) begin
        shells_reg    <= SHELLS_INIT;
        round_hit_reg <= 1'b0;
        fly_away_reg  <= 1'b0;
        cool_cnt_reg  <= 4'd0;
      end else begin
        case (state_reg)
          ARMED: begin
            if (shot_fire) begin
              shells_reg  <= shells_reg - 3'd1;
              cross_x_reg <= bus.Cross_X;
              cross_y_reg <= bus.Cross_Y;
              duck_x_reg  <= bus.Duck_X;
              duck_y_reg  <= bus.Duck_Y;
              color_reg   <= bus.Duck_color;
              live_reg    <= bus.duck_live;
            end
          end
          EVAL: begin
            cool_cnt_reg <= 4'd0;
            if (hit) begin
              kill_reg      <= 1'b1;
              round_hit_reg <= 1'b1;
              score_reg     <= score_add;
            end else if (shells_reg == 3'd0) begin
              fly_away_reg <= 1'b1;
            end
          end
          COOL: begin
            cool_cnt_reg <= cool_cnt_reg + 4'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef SHOT_FLASH_EN
  logic post_eval_reg;

  always_ff @(posedge ANIM_Clk or posedge Reset) begin
    if (Reset) begin
      post_eval_reg <= 1'b0;
    end else begin
      post_eval_reg <= (state_reg == EVAL);
    end
  end
`endif

  // Output logic
  always_comb begin
    bus.duck_kill_signal = kill_reg;
    bus.shells_left      = shells_reg;
    bus.round_hit        = round_hit_reg;
    bus.fly_away         = fly_away_reg;
    bus.Score_BCD        = score_reg;
`ifdef SHOT_FLASH_EN
    bus.flash            = (state_reg == EVAL) | post_eval_reg;
`endif
  end

endmodule
